// File: rtl/cdc_in_arbiter.sv
// Round-robin arbiter that shares the USB CDC IN byte channel among N_REQ byte-stream requesters.
// Optional macro CDC_ARB_PRIO0_EN gives requester 0 fixed priority during IDLE selection.
module cdc_in_arbiter #(
  parameter int N_REQ    = 2,
  parameter int HOLD_MAX = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ-1:0]   req_lock_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [7:0]         in_data_o,
  output logic               in_valid_o,
  input  logic               in_ready_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;

  logic [N_REQ-1:0] cand_s;
  logic             hit_s;
  logic [IW-1:0]    pick_s;
  logic             cap_s;
  logic             xfer_s;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int step);
    int sum;
    int wrap;
    sum = int'(base) + step;
    if (sum >= N_REQ) wrap = sum - N_REQ;
    else              wrap = sum;
    return IW'(wrap);
  endfunction

  // Requester selection: first candidate at or after last+1, wrapping.
  always_comb begin
    hit_s  = 1'b0;
    pick_s = '0;
    cand_s = req_valid_i | req_lock_i;
`ifdef CDC_ARB_PRIO0_EN
    if (cand_s[0]) begin
      hit_s  = 1'b1;
      pick_s = '0;
    end else begin
      for (int i = 1; i <= N_REQ; i++) begin
        if (!hit_s && (rr_idx(last_q, i) != '0) && cand_s[rr_idx(last_q, i)]) begin
          hit_s  = 1'b1;
          pick_s = rr_idx(last_q, i);
        end else begin
          pick_s = pick_s;
        end
      end
    end
`else
    for (int i = 1; i <= N_REQ; i++) begin
      if (!hit_s && cand_s[rr_idx(last_q, i)]) begin
        hit_s  = 1'b1;
        pick_s = rr_idx(last_q, i);
      end else begin
        pick_s = pick_s;
      end
    end
`endif
  end

  // Grant FSM, byte transfer and one-entry output stage next state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = valid_q;
    req_ready_o = '0;
    cap_s       = ~valid_q | in_ready_i;
    xfer_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_GRANT;
          owner_d = pick_s;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
          cnt_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        xfer_s               = req_valid_i[owner_q] & cap_s;
        req_ready_o[owner_q] = xfer_s;
        if (xfer_s) cnt_d = cnt_q + 8'd1;
        else        cnt_d = cnt_q;
        // A transfer reaching HOLD_MAX forces release even while locked.
        if ((!req_valid_i[owner_q] && !req_lock_i[owner_q]) ||
            (xfer_s && (({1'b0, cnt_q} + 9'd1) == 9'(HOLD_MAX)))) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    if (xfer_s) begin
      data_d  = req_data_i[{owner_q, 3'b000} +: 8];
      valid_d = 1'b1;
    end else if (in_ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      grant_q <= '0;
      cnt_q   <= 8'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign in_data_o  = data_q;
  assign in_valid_o = valid_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != ST_IDLE) | valid_q;

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// Bench for cdc_in_arbiter: requester queues feed two instances (HOLD_MAX 64 and 4); the expected
// output byte order is built from the arbitration rules and checked on every consumed byte.
module tb_cdc_in_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic [15:0] req_data;
  logic [1:0]  req_valid, req_lock;
  logic        in_ready;

  logic [1:0] ready_a, ready_b, grant_a, grant_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b;

  logic [1:0] m_ready, m_grant;
  logic [7:0] m_data;
  logic       m_valid, m_busy;

  assign m_ready = sel ? ready_b : ready_a;
  assign m_grant = sel ? grant_b : grant_a;
  assign m_data  = sel ? data_b  : data_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;

  cdc_in_arbiter #(.N_REQ(2), .HOLD_MAX(64)) dut (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_lock_i(req_lock), .req_ready_o(ready_a), .in_data_o(data_a), .in_valid_o(valid_a),
    .in_ready_i(in_ready), .grant_o(grant_a), .busy_o(busy_a));

  cdc_in_arbiter #(.N_REQ(2), .HOLD_MAX(4)) dut_h4 (
    .clk_i(clk), .rst_i(rst), .req_data_i(req_data), .req_valid_i(req_valid),
    .req_lock_i(req_lock), .req_ready_o(ready_b), .in_data_o(data_b), .in_valid_o(valid_b),
    .in_ready_i(in_ready), .grant_o(grant_b), .busy_o(busy_b));

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];
  logic       lk0, lk1;
  int         n_pass = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    else n_pass++;
  endtask

  task automatic drive();
    req_valid[0]   = (q0.size() > 0);
    req_lock[0]    = lk0 && (q0.size() > 0);
    req_data[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
    req_valid[1]   = (q1.size() > 0);
    req_lock[1]    = lk1 && (q1.size() > 0);
    req_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // Requesters: present queue heads, pop on an accepted byte.
  initial begin
    logic p0, p1;
    forever begin
      @(negedge clk);
      p0 = m_ready[0];
      p1 = m_ready[1];
      #1 drive();
      @(posedge clk);
      #1;
      if (p0 && q0.size() > 0) void'(q0.pop_front());
      if (p1 && q1.size() > 0) void'(q1.pop_front());
      drive();
    end
  end

  // Per-cycle compare: ready rule, grant shape, output hold under backpressure, byte order.
  initial begin
    logic [7:0] prev_data;
    logic       prev_stall;
    logic [1:0] exp_rdy;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("grant_onehot0", 32'($onehot0(m_grant)), 32'd1);
        exp_rdy = m_grant & req_valid & {2{~m_valid | in_ready}};
        check("ready_rule", 32'(m_ready), 32'(exp_rdy));
        if (prev_stall) begin
          check("hold_valid", 32'(m_valid), 32'd1);
          check("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && in_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL extra_byte: got %02h, expected no byte", m_data);
          end else begin
            check("byte_order", 32'(m_data), 32'(exp_q.pop_front()));
          end
        end
        prev_stall = m_valid && !in_ready;
        prev_data  = m_data;
      end
    end
  end

  task automatic do_reset(input logic which);
    rst = 1'b1; sel = which; in_ready = 1'b1; lk0 = 1'b0; lk1 = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0 || m_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    string banner;
    logic [7:0] d0;
    banner   = "UF16 v0.3\r\n\r\n";
    rst      = 1'b0;
    sel      = 1'b0;
    in_ready = 1'b1;
    lk0      = 1'b0;
    lk1      = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_grant", 32'(m_grant), 32'd0);
    check("rst_ready", 32'(m_ready), 32'd0);
    check("rst_data", 32'(m_data), 32'h00);
    check("rst_busy", 32'(m_busy), 32'd0);

    // Single byte 8'h33 from requester 0.
    do_reset(1'b0);
    q0.push_back(8'h33); exp_q.push_back(8'h33);
    @(negedge clk);
    @(negedge clk); check("t1_grant", 32'(m_grant), 32'd1);
    @(negedge clk); check("t1_valid", 32'(m_valid), 32'd1); check("t1_data", 32'(m_data), 32'h33);
    @(negedge clk); check("t1_valid_once", 32'(m_valid), 32'd0);
    check("t1_release", 32'(m_grant), 32'd0); check("t1_idle", 32'(m_busy), 32'd0);
    wait_drain("t1_drain");

    // Simultaneous requests, then a second contention.
    do_reset(1'b0);
    q0.push_back(8'hA1); q1.push_back(8'hB1);
`ifdef CDC_ARB_PRIO0_EN
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hB1);
`else
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB1); exp_q.push_back(8'hA2);
`endif
    @(negedge clk);
    @(negedge clk); check("t2_first_grant", 32'(m_grant), 32'd1);
    @(negedge clk);
    @(negedge clk); check("t2_released", 32'(m_grant), 32'd0);
    q0.push_back(8'hA2);
    @(negedge clk);
`ifdef CDC_ARB_PRIO0_EN
    check("t2_second_grant", 32'(m_grant), 32'd1);
`else
    check("t2_second_grant", 32'(m_grant), 32'd2);
`endif
    wait_drain("t2_drain");

    // Locked 13-byte banner from requester 1 against " 3" from requester 0.
    do_reset(1'b0);
    lk1 = 1'b1;
    for (int i = 0; i < banner.len(); i++) begin
      q1.push_back(banner[i]); exp_q.push_back(banner[i]);
    end
    check("t3_banner_len", 32'(exp_q.size()), 32'd13);
    @(posedge clk); #2;
    q0.push_back(8'h20); q0.push_back(8'h33);
    exp_q.push_back(8'h20); exp_q.push_back(8'h33);
    wait_drain("t3_drain");

    // HOLD_MAX=4: locked 10-byte stream from requester 0, one byte from requester 1.
    do_reset(1'b1);
    lk0 = 1'b1;
    for (int i = 0; i < 10; i++) q0.push_back(8'hC0 + 8'(i));
    q1.push_back(8'hD0);
`ifdef CDC_ARB_PRIO0_EN
    for (int i = 0; i < 10; i++) exp_q.push_back(8'hC0 + 8'(i));
    exp_q.push_back(8'hD0);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    exp_q.push_back(8'hD0);
    for (int i = 4; i < 10; i++) exp_q.push_back(8'hC0 + 8'(i));
`endif
    wait_drain("t4_drain");

    // 20-cycle backpressure mid-burst.
    do_reset(1'b0);
    lk0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(8'hE0 + 8'(i)); exp_q.push_back(8'hE0 + 8'(i));
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #2 in_ready = 1'b0;
    @(negedge clk);
    d0 = m_data;
    for (int i = 0; i < 20; i++) begin
      check("stall_ready", 32'(m_ready), 32'd0);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_data", 32'(m_data), 32'(d0));
      @(negedge clk);
    end
    @(posedge clk); #2 in_ready = 1'b1;
    wait_drain("t5_drain");

    // Reset while a byte is held and the grant is active (HOLD_MAX=4 instance).
    do_reset(1'b1);
    lk0 = 1'b1;
    for (int i = 0; i < 6; i++) q0.push_back(8'h60 + 8'(i));
    exp_q.push_back(8'h60);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 in_ready = 1'b0;
    @(negedge clk);
    check("t6_pre_valid", 32'(m_valid), 32'd1);
    check("t6_pre_grant", 32'(m_grant), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(m_valid), 32'd0);
    check("t6_rst_grant", 32'(m_grant), 32'd0);
    check("t6_rst_ready", 32'(m_ready), 32'd0);
    check("t6_rst_data", 32'(m_data), 32'h00);
    check("t6_rst_busy", 32'(m_busy), 32'd0);
    check("t6_consumed", 32'(exp_q.size()), 32'd0);
    q0.delete(); q1.delete(); exp_q.delete(); lk0 = 1'b0; in_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    lk0 = 1'b1;
    for (int i = 0; i < 5; i++) q0.push_back(8'h70 + 8'(i));
    q1.push_back(8'h7F);
`ifdef CDC_ARB_PRIO0_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h70 + 8'(i));
    exp_q.push_back(8'h7F);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h70 + 8'(i));
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h74);
`endif
    @(negedge clk);
    @(negedge clk); check("t6_regrant0", 32'(m_grant), 32'd1);
    wait_drain("t6_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
